sprite_move_ctrl: RTL and testbench

- Upstream command generator for the 16x16 sprite stage.
- Turns debounced push-button levels into the sprite's position and colour command strobes: change-pos, absolute, signed X/Y deltas, new colour and set-colour.
- Issues at most one position command per video frame, at the start of vertical blanking.
- Keeps a shadow copy of the sprite position and clamps moves so the sprite stays on screen.

---
 rtl/sprite_move_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sprite_move_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_ctrl.sv
// Frame-synchronous sprite command generator: buttons -> clamped position/colour strobes.
// Optional auto-repeat of held directions: define SPRITE_AUTOREPEAT_EN.
module sprite_move_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int STEP = 4,
    parameter logic [4:0] HOME_X = 5'd9,
    parameter logic [4:0] HOME_Y = 5'd7
`ifdef SPRITE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 8
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] iColumnCount,
    input  logic [9:0] iRowCount,
    input  logic       iBtnUp,
    input  logic       iBtnDown,
    input  logic       iBtnLeft,
    input  logic       iBtnRight,
    input  logic       iBtnColor,
    input  logic       iBtnHome,
    output logic       oChangePos,
    output logic       oAbsolute,
    output logic [4:0] oSetX,
    output logic [4:0] oSetY,
    output logic [2:0] oNewColor,
    output logic       oSetColor
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_EVAL  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - 16);
    localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - 16);

    // bit order: {home, color, right, left, down, up}
    logic [5:0] btn, sync1, sync2, prev, rise, pend, pend_next, rearm;
    logic       tick;
    state_t     state, next_state;

    logic              cmd_pos, cmd_abs, cmd_col;
    logic [4:0]        cmd_dx, cmd_dy;
    logic [2:0]        color;
    logic signed [10:0] sx, sy;
    logic signed [10:0] dx_raw, dy_raw, nx, ny, dx, dy, dxe, dye;

    assign btn = {iBtnHome, iBtnColor, iBtnRight, iBtnLeft, iBtnDown, iBtnUp};
    assign rise = sync2 & ~prev;
    assign pend_next = ((state == S_EVAL) ? 6'd0 : pend) | rise | rearm;
    assign dxe = {{6{cmd_dx[4]}}, cmd_dx};
    assign dye = {{6{cmd_dy[4]}}, cmd_dy};
    assign oNewColor = color;

`ifdef SPRITE_AUTOREPEAT_EN
    localparam int CW = $clog2(REPEAT_FRAMES + 1);
    logic [CW-1:0] cnt_h, cnt_v;
    logic          held_h, held_v;

    assign held_h = sync2[2] | sync2[3];
    assign held_v = sync2[0] | sync2[1];

    always_comb begin
        rearm = '0;
        if (tick && held_h && cnt_h == CW'(REPEAT_FRAMES))
            rearm[3:2] = sync2[3:2];
        if (tick && held_v && cnt_v == CW'(REPEAT_FRAMES))
            rearm[1:0] = sync2[1:0];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else begin
            if (!held_h)
                cnt_h <= '0;
            else if (tick)
                cnt_h <= (cnt_h == CW'(REPEAT_FRAMES)) ? CW'(1) : cnt_h + 1'b1;
            if (!held_v)
                cnt_v <= '0;
            else if (tick)
                cnt_v <= (cnt_v == CW'(REPEAT_FRAMES)) ? CW'(1) : cnt_v + 1'b1;
        end
    end
`else
    assign rearm = '0;
`endif

    // Opposing buttons cancel; the step is then trimmed to the screen edge.
    always_comb begin
        dx_raw = '0;
        dy_raw = '0;
        if (pend[3] && !pend[2]) dx_raw = STEP_S;
        else if (pend[2] && !pend[3]) dx_raw = -STEP_S;
        if (pend[1] && !pend[0]) dy_raw = STEP_S;
        else if (pend[0] && !pend[1]) dy_raw = -STEP_S;
        nx = sx + dx_raw;
        ny = sy + dy_raw;
        if (nx < 0) dx = -sx;
        else if (nx > X_MAX) dx = X_MAX - sx;
        else dx = dx_raw;
        if (ny < 0) dy = -sy;
        else if (ny > Y_MAX) dy = Y_MAX - sy;
        else dy = dy_raw;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pend    <= '0;
            tick    <= 1'b0;
            state   <= S_WAIT;
            cmd_pos <= 1'b0;
            cmd_abs <= 1'b0;
            cmd_col <= 1'b0;
            cmd_dx  <= '0;
            cmd_dy  <= '0;
            color   <= '0;
            sx      <= '0;
            sy      <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= pend_next;
            tick  <= (iRowCount == 10'(V_ACTIVE)) && (iColumnCount == 10'd0);
            state <= next_state;
            if (state == S_EVAL) begin
                cmd_abs <= pend[5];
                cmd_col <= pend[4];
                if (pend[5]) begin
                    cmd_pos <= 1'b1;
                    cmd_dx  <= HOME_X;
                    cmd_dy  <= HOME_Y;
                end else begin
                    cmd_pos <= (dx != 0) || (dy != 0);
                    cmd_dx  <= dx[4:0];
                    cmd_dy  <= dy[4:0];
                end
                if (pend[4])
                    color <= (color == 3'd7 || color == 3'd0) ? 3'd1 : color + 3'd1;
            end
            if (state == S_ISSUE && cmd_pos) begin
                if (cmd_abs) begin
                    sx <= {1'b0, HOME_X, 5'b0};
                    sy <= {1'b0, HOME_Y, 5'b0};
                end else begin
                    sx <= sx + dxe;
                    sy <= sy + dye;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        oChangePos = 1'b0;
        oAbsolute  = 1'b0;
        oSetX      = '0;
        oSetY      = '0;
        oSetColor  = 1'b0;
        unique case (state)
            S_WAIT: if (tick) next_state = S_EVAL;
            S_EVAL: next_state = S_ISSUE;
            S_ISSUE: begin
                oChangePos = cmd_pos;
                oAbsolute  = cmd_abs;
                oSetX      = cmd_dx;
                oSetY      = cmd_dy;
                oSetColor  = cmd_col;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl: frame-level model checked every cycle
// plus literal expectations for the main scenarios.
module tb_sprite_move_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] col = '0, row = '0;
    logic [5:0] btn = '0;
    logic       oChangePos, oAbsolute, oSetColor;
    logic [4:0] oSetX, oSetY;
    logic [2:0] oNewColor;

`ifdef SPRITE_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    sprite_move_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .iColumnCount(col), .iRowCount(row),
        .iBtnUp(btn[0]), .iBtnDown(btn[1]),
        .iBtnLeft(btn[2]), .iBtnRight(btn[3]),
        .iBtnColor(btn[4]), .iBtnHome(btn[5]),
        .oChangePos(oChangePos), .oAbsolute(oAbsolute),
        .oSetX(oSetX), .oSetY(oSetY),
        .oNewColor(oNewColor), .oSetColor(oSetColor)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model state: shadow position and colour
    int mx = 0, my = 0, mcol = 0;
    bit e_pos = 0, e_abs = 0, e_sc = 0;
    logic [4:0] e_x = '0, e_y = '0;
    int col_old = 0, col_new = 0, issue_cyc = -100;
    bit checking = 0;

    int strobes = 0, cstrobes = 0;
    bit cap_abs = 0, both = 0;
    logic [4:0] cap_x = '0, cap_y = '0;

    always @(negedge Clock) begin
        bit iss;
        if (checking) begin
            iss = (cyc == issue_cyc);
            check("chgpos", oChangePos, iss ? e_pos : 1'b0);
            check("absolute", oAbsolute, iss ? e_abs : 1'b0);
            check("setx", oSetX, iss ? e_x : 5'd0);
            check("sety", oSetY, iss ? e_y : 5'd0);
            check("setcolor", oSetColor, iss ? e_sc : 1'b0);
            check("newcolor", oNewColor, (cyc >= issue_cyc) ? col_new : col_old);
            if (oChangePos) begin
                strobes++;
                cap_abs = oAbsolute;
                cap_x = oSetX;
                cap_y = oSetY;
                if (oSetColor) both = 1;
            end
            if (oSetColor) cstrobes++;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic int clampd(input int pos, input int d, input int mx_);
        if (pos + d < 0) return -pos;
        if (pos + d > mx_) return mx_ - pos;
        return d;
    endfunction

    // One frame: drive buttons, then a frame tick. mp is what the model
    // treats as newly pending at that tick.
    task automatic frame(input logic [5:0] drive, input logic [5:0] mp,
                         input bit hold, input bit late);
        bit p_pos, p_abs, p_sc;
        logic [4:0] px, py;
        int pc_old, dx, dy;
        pc_old = mcol;
        p_abs = 0; p_sc = 0; p_pos = 0; px = '0; py = '0;
        if (mp[5]) begin
            p_abs = 1; p_pos = 1; px = 5'd9; py = 5'd7;
            mx = 9 * 32; my = 7 * 32;
        end else begin
            dx = (mp[3] ? 4 : 0) - (mp[2] ? 4 : 0);
            dy = (mp[1] ? 4 : 0) - (mp[0] ? 4 : 0);
            dx = clampd(mx, dx, 640 - 16);
            dy = clampd(my, dy, 480 - 16);
            mx += dx; my += dy;
            p_pos = (dx != 0) || (dy != 0);
            px = 5'(dx); py = 5'(dy);
        end
        if (mp[4]) begin
            mcol = (mcol == 7 || mcol == 0) ? 1 : mcol + 1;
            p_sc = 1;
        end
        if (!late) begin
            btn = drive;
            repeat (4) step();
            if (!hold) btn = '0;
            repeat (4) step();
        end
        row = 10'd480; col = 10'd0;
        e_pos = p_pos; e_abs = p_abs; e_sc = p_sc; e_x = px; e_y = py;
        col_old = pc_old; col_new = mcol; issue_cyc = cyc + 3;
        if (late) btn = drive;
        step();
        row = 10'd0; col = 10'd1;
        repeat (4) step();
        if (late && !hold) btn = '0;
        repeat (4) step();
    endtask

    localparam logic [5:0] U = 6'b000001, D = 6'b000010, L = 6'b000100;
    localparam logic [5:0] R = 6'b001000, C = 6'b010000, H = 6'b100000;

    initial begin
        int s0;
        #2 Reset = 1'b0;
        repeat (3) step();
        check("rst_chgpos", oChangePos, 1'b0);
        check("rst_abs", oAbsolute, 1'b0);
        check("rst_setx", oSetX, 5'd0);
        check("rst_sety", oSetY, 5'd0);
        check("rst_color", oNewColor, 3'd0);
        check("rst_setcolor", oSetColor, 1'b0);
        Reset = 1'b1;
        step();
        checking = 1;

        frame(R, R, 0, 0);
        check("right_strobes", strobes, 1);
        check("right_x", cap_x, 5'b00100);
        check("right_y", cap_y, 5'b00000);
        check("right_abs", cap_abs, 1'b0);

        frame(L, L, 0, 0);
        check("left_x", cap_x, 5'b11100);
        s0 = strobes;
        frame(L, L, 0, 0);
        check("left_clamped", strobes, s0);
        frame(U, U, 0, 0);
        check("up_clamped", strobes, s0);

        frame(U | D | R, U | D | R, 0, 0);
        check("udr_strobes", strobes, s0 + 1);
        check("udr_x", cap_x, 5'd4);
        check("udr_y", cap_y, 5'd0);

        frame(D, D, 0, 0);
        frame(H | L, H | L, 0, 0);
        check("home_abs", cap_abs, 1'b1);
        check("home_x", cap_x, 5'd9);
        check("home_y", cap_y, 5'd7);
        frame(R, R, 0, 0);
        check("after_home_x", cap_x, 5'd4);

        for (int i = 0; i < 7; i++) frame(C, C, 0, 0);
        check("color_7", oNewColor, 3'd7);
        frame(C | D, C | D, 0, 0);
        check("color_wrap", oNewColor, 3'd1);
        check("color_strobes", cstrobes, 8);
        check("color_with_move", both, 1'b1);

        frame(C, 6'd0, 0, 1);
        check("late_not_yet", oNewColor, 3'd1);
        frame(6'd0, C, 0, 0);
        check("late_latched", oNewColor, 3'd2);

        s0 = strobes;
        for (int i = 0; i < 20; i++)
            frame(R, (i == 0 || (AUTO && i % 8 == 0)) ? R : 6'd0, 1, 0);
        check("hold_strobes", strobes - s0, AUTO ? 3 : 1);
        frame(6'd0, 6'd0, 0, 0);
        frame(L, L, 0, 0);
        check("final_left", cap_x, 5'b11100);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
